// File: rtl/matmul_apb_master.sv
// APB initiator: turns single-beat host commands into APB SETUP/ACCESS transfers and
// returns the slave response on a valid/ready channel, with an ACCESS-phase timeout.
module matmul_apb_master #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_DIM        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Host command channel
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  // Host response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  // APB initiator
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  // Counter must hold TIMEOUT_CYCLES; keep at least one bit when the timeout is disabled.
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // Last permitted wait cycle reached with the slave still stalling.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // Single FSM driving every output from registers; the APB outputs double as the
  // registered command, so they cannot change while psel_o is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_slverr_o  <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            state_q     <= StSetup;
            cmd_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            penable_o   <= 1'b0;
            pwrite_o    <= cmd_write_i;
            paddr_o     <= cmd_addr_i;
            // Reads drive no data and no strobes.
            pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_o     <= cmd_write_i ? cmd_strb_i : '0;
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_o <= 1'b1;
          cnt_q     <= '0;
        end
        StAccess: begin
          if (pready_i || timeout_hit) begin
            state_q       <= StResp;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_valid_o   <= 1'b1;
            // A ready slave wins over a coincident timeout.
            if (pready_i) begin
              rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
              rsp_slverr_o  <= pslverr_i;
              rsp_timeout_o <= 1'b0;
            end else begin
              rsp_rdata_o   <= '0;
              rsp_slverr_o  <= 1'b1;
              rsp_timeout_o <= 1'b1;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q       <= StIdle;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_slverr_o  <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cmd_ready_o   <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: table of single transfers plus hand-written
// sequences for response backpressure and reset during ACCESS.
module tb_matmul_apb_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [15:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_strb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_slverr_o;
  logic        rsp_timeout_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [15:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;
  logic [31:0] prdata_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  matmul_apb_master #(
    .BUS_WIDTH     (32),
    .ADDR_WIDTH    (16),
    .MAX_DIM       (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_strb_i   (cmd_strb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_slverr_o (rsp_slverr_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i),
    .prdata_i     (prdata_i)
  );

  // wait_states < 0 means the slave never raises pready.
  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_states;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    logic        exp_timeout;
    int          exp_pen;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge of the SETUP cycle.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    @(negedge clk_i);
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_wdata_i = 32'hFFFF_FFFF;
    cmd_addr_i  = 16'hFFFF;
    cmd_strb_i  = 4'hF;
  endtask

  // Check SETUP, act as slave through ACCESS, then check the response.
  task automatic access_phase(input vec_t v);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    int          pen;
    exp_wd = v.write ? v.wdata : 32'd0;
    exp_st = v.write ? v.strb : 4'd0;
    chk("setup_psel", {31'd0, psel_o}, 32'd1);
    chk("setup_penable", {31'd0, penable_o}, 32'd0);
    chk("setup_paddr", {16'd0, paddr_o}, {16'd0, v.addr});
    chk("setup_pwrite", {31'd0, pwrite_o}, {31'd0, v.write});
    chk("setup_pwdata", pwdata_o, exp_wd);
    chk("setup_pstrb", {28'd0, pstrb_o}, {28'd0, exp_st});
    pen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (!(psel_o && penable_o)) break;
      pen++;
      chk("access_paddr", {16'd0, paddr_o}, {16'd0, v.addr});
      chk("access_pwdata", pwdata_o, exp_wd);
      chk("access_pstrb", {28'd0, pstrb_o}, {28'd0, exp_st});
      prdata_i  = v.prdata;
      pslverr_i = v.slverr;
      pready_i  = (v.wait_states >= 0) && (pen == v.wait_states + 1);
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    chk("access_cycles", pen, v.exp_pen);
    chk("resp_psel", {31'd0, psel_o}, 32'd0);
    chk("resp_paddr", {16'd0, paddr_o}, 32'd0);
    chk("resp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("resp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("resp_rdata", rsp_rdata_o, v.exp_rdata);
    chk("resp_slverr", {31'd0, rsp_slverr_o}, {31'd0, v.exp_slverr});
    chk("resp_timeout", {31'd0, rsp_timeout_o}, {31'd0, v.exp_timeout});
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("after_hs_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("after_hs_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    vec_t v;
    // write, addr, wdata, strb, waits, prdata, pslverr, exp_rdata, exp_err, exp_to, exp_pen
    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 16'h0004, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b1, 16'h0020, 32'hCAFEF00D, 4'h3, 1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 16'h0008, 32'h0, 4'h0, 0, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b0, 1'b0, 1};
    vecs[4] = '{1'b0, 16'h00F0, 32'h0, 4'h0, -1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 1'b1, 8};
    vecs[5] = '{1'b1, 16'h0044, 32'h76543210, 4'h9, 7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8};
    vecs[6] = '{1'b0, 16'h0100, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, 3};
    vecs[7] = '{1'b1, 16'hFFFC, 32'h00000001, 4'h1, 0, 32'h11111111, 1'b0, 32'h0, 1'b0, 1'b0, 1};

    // Reset state
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      issue(v.write, v.addr, v.wdata, v.strb);
      access_phase(v);
      consume();
    end

    // Backpressure: response held 5 cycles while a second command waits.
    issue(1'b1, 16'h0030, 32'h01020304, 4'hF);
    v = '{1'b1, 16'h0030, 32'h01020304, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1};
    access_phase(v);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 16'h0040;
    cmd_wdata_i = 32'h0;
    cmd_strb_i  = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp_rdata", rsp_rdata_o, 32'd0);
      chk("bp_slverr", {31'd0, rsp_slverr_o}, 32'd0);
      chk("bp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("bp_psel", {31'd0, psel_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("bp_idle_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("bp_idle_psel", {31'd0, psel_o}, 32'd0);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    v = '{1'b0, 16'h0040, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 1};
    access_phase(v);
    consume();

    // Reset during an ACCESS wait state.
    issue(1'b0, 16'h0080, 32'h0, 4'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_pre_penable", {31'd0, penable_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
    chk("mid_rst_penable", {31'd0, penable_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rel_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("mid_rel_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("mid_rel_psel", {31'd0, psel_o}, 32'd0);

    // Block still usable after the reset.
    v = '{1'b1, 16'h0018, 32'hFEEDFACE, 4'hC, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2};
    issue(v.write, v.addr, v.wdata, v.strb);
    access_phase(v);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- APB initiator for the matmul accelerator's APB slave port.
- Turns single-beat commands from a host-side valid/ready channel into APB SETUP/ACCESS transfers, waits for pready, and returns prdata and pslverr on a valid/ready response channel.
- Adds an access-phase timeout so a hung slave never deadlocks the initiator.
- Used by the system-level wrapper and as a synthesizable bus driver in directed tests.

Parameters:
- BUS_WIDTH, 32, width of pwdata/prdata and of command/response data.
- ADDR_WIDTH, 16, width of paddr and command address.
- MAX_DIM, 4, width of the write strobe (one bit per byte lane).
- TIMEOUT_CYCLES, 64, maximum ACCESS cycles before forced termination; 0 disables the timeout.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  input  1  1 = write, 0 = read.
- cmd_addr_i  input  ADDR_WIDTH  target address.
- cmd_wdata_i  input  BUS_WIDTH  write data.
- cmd_strb_i  input  MAX_DIM  write byte strobes.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  BUS_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr_o  output  1  slave error or timeout.
- rsp_timeout_o  output  1  transfer terminated by timeout.
- psel_o, penable_o, pwrite_o  output  1 each  APB control.
- paddr_o  output  ADDR_WIDTH  APB address.
- pwdata_o  output  BUS_WIDTH  APB write data.
- pstrb_o  output  MAX_DIM  APB strobes.
- pready_i, pslverr_i  input  1 each  APB slave response.
- prdata_i  input  BUS_WIDTH  APB read data.

Behaviour:
- Reset (asynchronous, rst_ni low): state IDLE.
  - All outputs 0 except cmd_ready_o = 1.
  - Timeout counter cleared.
  - Reset mid-transfer drops psel_o/penable_o immediately and discards the pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1. cmd_ready_o is 0 in every other state.
  - On cmd_valid_i & cmd_ready_o: register write, addr, wdata, strb; go to SETUP.
- SETUP (exactly 1 cycle):
  - psel_o = 1, penable_o = 0, paddr_o/pwrite_o driven from the registered command.
  - Write: pwdata_o = wdata, pstrb_o = strb. Read: pwdata_o = 0, pstrb_o = 0.
  - Next state ACCESS; counter cleared.
- ACCESS:
  - psel_o = 1, penable_o = 1; paddr_o, pwrite_o, pwdata_o and pstrb_o held stable.
  - When pready_i is sampled high:
    - Capture rsp_rdata_o = prdata_i for reads, 0 for writes.
    - rsp_slverr_o = pslverr_i; rsp_timeout_o = 0.
    - Go to RESP.
  - When pready_i is low: counter increments.
  - Timeout, when TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES-1 with pready_i still low:
    - Go to RESP with rdata = 0, slverr = 1, timeout = 1.
  - pready_i high on the timeout cycle takes priority: normal completion.
  - Minimum transfer is 2 APB cycles (zero-wait slave). Command-accept to rsp_valid_o is 3 cycles.
- RESP:
  - psel_o = 0, penable_o = 0; all APB outputs return to 0.
  - rsp_valid_o = 1; response fields held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i: go to IDLE. No back-to-back bypass: the next command is accepted one cycle later.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; saturates, never wraps.
- The block never asserts psel_o outside SETUP/ACCESS and never changes command fields while psel_o = 1.
- Command inputs are ignored outside IDLE.
- With TIMEOUT_CYCLES = 0, ACCESS waits indefinitely.

Test Plan:
- Zero-wait write (cmd addr=0x0010, wdata=0xDEADBEEF, strb=0xF, pready tied 1):
  - SETUP then ACCESS, each exactly one cycle, with paddr=0x0010, pwdata=0xDEADBEEF, pstrb=0xF.
  - rsp_valid 3 cycles after accept; rdata=0, slverr=0.
- Read with 3 wait states (addr=0x0004, prdata=0x12345678 when pready rises):
  - penable high 4 cycles with paddr stable.
  - rsp_rdata=0x12345678, pstrb=0 throughout.
- Slave error: write with pslverr=1 on the pready cycle -> rsp_slverr=1, rsp_timeout=0.
- Timeout (TIMEOUT_CYCLES=8, pready held 0):
  - ACCESS lasts exactly 8 cycles, then psel drops.
  - rsp_slverr=1, rsp_timeout=1, rdata=0.
- Response backpressure: rsp_ready low 5 cycles.
  - rsp fields stable, cmd_ready=0 throughout, no new psel.
  - Second command accepted the cycle after the handshake.
- Reset mid-ACCESS: assert rst_ni low during a wait state.
  - psel/penable go 0 asynchronously; rsp_valid=0, cmd_ready=1 after release.
